// File: rtl/rgb565_gray_sequencer.sv
// rtl/rgb565_gray_sequencer.sv - four-pixel RGB565 to 8-bit grayscale custom instruction, one shared datapath
//
// Ports:
//   clock   - system clock, all state on the rising edge
//   resetN  - asynchronous active-low reset
//   start   - custom-instruction start strobe
//   iseId   - custom-instruction number accompanying start
//   valueA  - pixel1 [31:16], pixel0 [15:0], RGB565 {r5,g6,b5}
//   valueB  - pixel3 [31:16], pixel2 [15:0]
//   done    - one-cycle completion pulse
//   result  - {gray3,gray2,gray1,gray0} while done=1, else zero
//
// Build option: GRAY_SEQ_PIPE_EN adds a register between the multipliers and
// the adder plus a one-cycle DRAIN state; done arrives one cycle later.
module rgb565_gray_sequencer #(
    parameter logic [7:0] customInstructionId = 8'd14
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] op_q, op_d;
    logic [31:0] acc_q, acc_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [15:0] pix;
    logic [15:0] prod_r, prod_g, prod_b;
    logic [15:0] sum;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [31:0] acc_wr;
    logic        accept;

    assign accept = (state_q == S_IDLE) && start && (iseId == customInstructionId);

    always_comb begin
        pix = op_q[15:0];
        case (cnt_q)
            2'd0: pix = op_q[15:0];
            2'd1: pix = op_q[31:16];
            2'd2: pix = op_q[47:32];
            2'd3: pix = op_q[63:48];
            default: pix = op_q[15:0];
        endcase
    end

    // Channels are widened to 8 bits by zero-filling the low bits, not by replication.
    assign prod_r = {8'b0, pix[15:11], 3'b000} * 16'd54;
    assign prod_g = {8'b0, pix[10:5],  2'b00}  * 16'd183;
    assign prod_b = {8'b0, pix[4:0],   3'b000} * 16'd19;

`ifdef GRAY_SEQ_PIPE_EN
    logic [15:0] pr_q, pg_q, pb_q;
    logic        wv_q;
    logic [1:0]  widx_q;

    // The byte index travels with the products so the write lands one cycle later.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pr_q   <= '0;
            pg_q   <= '0;
            pb_q   <= '0;
            wv_q   <= 1'b0;
            widx_q <= '0;
        end else begin
            pr_q   <= prod_r;
            pg_q   <= prod_g;
            pb_q   <= prod_b;
            wv_q   <= (state_q == S_CONV);
            widx_q <= cnt_q;
        end
    end

    assign sum    = pr_q + pg_q + pb_q;
    assign wr_en  = wv_q;
    assign wr_idx = widx_q;
`else
    assign sum    = prod_r + prod_g + prod_b;
    assign wr_en  = (state_q == S_CONV);
    assign wr_idx = cnt_q;
`endif

    // Accumulator with this cycle's byte merged in; it also feeds the output
    // register so the final byte is visible in the same cycle done rises.
    always_comb begin
        acc_wr = acc_q;
        if (wr_en) begin
            acc_wr[{wr_idx, 3'b000} +: 8] = 8'(sum >> 8);
        end
    end

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_CONV;
            S_CONV: begin
                if (cnt_q == 2'd3) begin
`ifdef GRAY_SEQ_PIPE_EN
                    state_d = S_DRAIN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath control
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_wr;
        if (accept) begin
            op_d  = {valueB, valueA};
            cnt_d = 2'd0;
            acc_d = '0;
        end else if (state_q == S_CONV) begin
            cnt_d = cnt_q + 2'd1;
        end
        done_d   = (state_d == S_DONE);
        result_d = done_d ? acc_wr : 32'd0;
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rgb565_gray_sequencer.sv
// tb/tb_rgb565_gray_sequencer.sv - self-checking bench for rgb565_gray_sequencer
module tb_rgb565_gray_sequencer;

`ifdef GRAY_SEQ_PIPE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  iseId = 8'd0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic        done;
    logic [31:0] result;

    rgb565_gray_sequencer #(.customInstructionId(8'd14)) dut (
        .clock  (clock),
        .resetN (resetN),
        .start  (start),
        .iseId  (iseId),
        .valueA (valueA),
        .valueB (valueB),
        .done   (done),
        .result (result)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] gray(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]) * 8;
        g = int'(p[10:5]) * 4;
        b = int'(p[4:0]) * 8;
        return 8'((r * 54 + g * 183 + b * 19) / 256);
    endfunction

    function automatic logic [31:0] pack(input logic [31:0] a, input logic [31:0] b);
        return {gray(b[31:16]), gray(b[15:0]), gray(a[31:16]), gray(a[15:0])};
    endfunction

    // Reference model: cycle counter, pending completion and busy window.
    int          cyc = 0;
    int          free_at = 0;
    int          pend_cycle = -1;
    logic [31:0] pend_res = '0;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!resetN) begin
            pend_cycle <= -1;
            free_at    <= 0;
        end else if (start && iseId == 8'd14 && cyc >= free_at) begin
            pend_cycle <= cyc + LAT;
            pend_res   <= pack(valueA, valueB);
            free_at    <= cyc + LAT + 1;
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clock) begin
        logic        exp_done;
        logic [31:0] exp_res;
        if (chk_en) begin
            exp_done = resetN && (cyc == pend_cycle);
            exp_res  = exp_done ? pend_res : 32'd0;
            check("cyc_done", {31'd0, done}, {31'd0, exp_done});
            check("cyc_result", result, exp_res);
        end
    end

    task automatic step(input logic s, input logic [7:0] id, input logic [31:0] a, input logic [31:0] b);
        start = s; iseId = id; valueA = a; valueB = b;
        @(posedge clock); #1;
    endtask

    int          d_n;
    int          d_off [4];
    logic [31:0] d_res [4];

    // Accept a start, then watch nk cycles; optional busy start and restart.
    task automatic run_seq(input logic [31:0] a, input logic [31:0] b, input int nk,
                           input int busy_k, input int again_k,
                           input logic [31:0] a2, input logic [31:0] b2);
        d_n = 0;
        step(1'b1, 8'd14, a, b);
        for (int k = 1; k <= nk; k++) begin
            if (k == busy_k) begin
                start = 1'b1; iseId = 8'd14; valueA = 32'd0; valueB = 32'd0;
            end else if (k == again_k) begin
                start = 1'b1; iseId = 8'd14; valueA = a2; valueB = b2;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done) begin
                if (d_n < 4) begin
                    d_off[d_n] = k;
                    d_res[d_n] = result;
                end
                d_n++;
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int cnt;

        // Model pinned against hand-computed values.
        check("model_mixed", pack(32'hF800FFFF, 32'h001F07E0), 32'h12B434FA);
        check("model_bw", pack(32'h0000FFFF, 32'hFFFF0000), 32'hFA0000FA);

        // Reset held with a matching start pending.
        resetN = 1'b0; start = 1'b1; iseId = 8'd14; valueA = 32'hFFFFFFFF; valueB = 32'hFFFFFFFF;
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(posedge clock); #1;
        start = 1'b0;
        resetN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) cnt++;
            @(posedge clock); #1;
        end
        check("post_reset_idle_pulses", cnt, 0);

        // Wrong id.
        step(1'b1, 8'd47, 32'hFFFFFFFF, 32'hFFFFFFFF);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) cnt++;
            @(posedge clock); #1;
        end
        check("wrong_id_pulses", cnt, 0);
        @(negedge clock);
        check("wrong_id_result", result, 32'd0);
        @(posedge clock); #1;

        // Mixed colours.
        run_seq(32'hF800FFFF, 32'h001F07E0, LAT + 4, 0, 0, 32'd0, 32'd0);
        check("mixed_pulses", d_n, 1);
        check("mixed_latency", d_off[0], LAT);
        check("mixed_result", d_res[0], 32'h12B434FA);

        // Black and white.
        run_seq(32'h0000FFFF, 32'hFFFF0000, LAT + 4, 0, 0, 32'd0, 32'd0);
        check("bw_pulses", d_n, 1);
        check("bw_result", d_res[0], 32'hFA0000FA);

        // Busy start ignored, back-to-back start accepted.
        run_seq(32'hF800FFFF, 32'h001F07E0, 2 * LAT + 3, 2, LAT + 1, 32'h0000FFFF, 32'hFFFF0000);
        check("b2b_pulses", d_n, 2);
        check("b2b_first_latency", d_off[0], LAT);
        check("b2b_first_result", d_res[0], 32'h12B434FA);
        check("b2b_second_latency", d_off[1], 2 * LAT + 1);
        check("b2b_second_result", d_res[1], 32'hFA0000FA);

        // Reset mid-conversion.
        step(1'b1, 8'd14, 32'hF800FFFF, 32'h001F07E0);
        start = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b0;
        #1;
        check("midop_done", {31'd0, done}, 32'd0);
        check("midop_result", result, 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) cnt++;
            @(posedge clock); #1;
        end
        check("midop_pulses", cnt, 0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                resetN = 1'b0;
                step(1'b0, 8'd0, 32'd0, 32'd0);
                resetN = 1'b1;
            end else begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0) ? 8'd14 : 8'($urandom),
                     $urandom, $urandom);
            end
        end
        step(1'b0, 8'd0, 32'd0, 32'd0);
        repeat (LAT + 2) step(1'b0, 8'd0, 32'd0, 32'd0);

        chk_en = 1'b0;
        @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
